debounce_scan_ctrl: RTL and testbench

Multi-channel debounce scheduler that shares one counter/compare datapath among `N_CH` raw button inputs. A round-robin scan pointer services one channel per clock. Each channel keeps its own stable level and its own count register, and all channels share a runtime `delay` setting. Every committed level change is reported through a single-entry valid/ready event port, so the downstream controller can consume presses and releases without polling `out`.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_sync.sv | 23 ++
 rtl/debounce_scan_ctrl.sv | 103 ++++++++++
 tb/tb_debounce_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and the event record for the scanned debounce controller.
package debounce_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    // Wide enough for up to 256 channels; the top narrows it to its own index width.
    localparam int EVT_CH_W = 8;

    typedef struct packed {
        logic [EVT_CH_W-1:0] ch;
        logic                level;
    } debounce_evt_t;

endpackage

// File: rtl/debounce_sync.sv
// Vector two-flop synchronizer for asynchronous button inputs.
module debounce_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debounce scheduler: one shared increment/compare serves every channel,
// committed level changes are reported through a single-entry valid/ready event port.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         in,
    input  logic [CNT_W-1:0]        delay,
    output logic [N_CH-1:0]         out,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_level,
    output logic                    evt_overrun
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  sync;
    logic [CH_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt [N_CH];
    debounce_evt_t    evt_q;

    logic [CNT_W:0]   cnt_next;
    logic [CNT_W:0]   eff;
    logic             differ;
    logic             commit;

    debounce_sync #(.WIDTH(N_CH)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (in),
        .q       (sync)
    );

    // One extra bit keeps cnt+1 from wrapping before the compare.
    always_comb begin
        eff      = (delay == '0) ? (CNT_W+1)'(1) : {1'b0, delay};
        cnt_next = {1'b0, cnt[ptr]} + (CNT_W+1)'(1);
        differ   = (sync[ptr] != out[ptr]);
        commit   = differ && (cnt_next >= eff);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (ptr == CH_W'(N_CH - 1)) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + CH_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (!differ || commit) begin
            cnt[ptr] <= '0;
        end else begin
            cnt[ptr] <= cnt_next[CNT_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
        end else if (commit) begin
            out[ptr] <= sync[ptr];
        end
    end

    // A commit against a held, unaccepted event is dropped but still flagged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid   <= 1'b0;
            evt_q       <= '0;
            evt_overrun <= 1'b0;
        end else begin
            evt_overrun <= 1'b0;
            if (commit) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid   <= 1'b1;
                    evt_q.ch    <= EVT_CH_W'(ptr);
                    evt_q.level <= sync[ptr];
                end else begin
                    evt_overrun <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

    assign evt_ch    = CH_W'(evt_q.ch);
    assign evt_level = evt_q.level;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Scoreboard bench for debounce_scan_ctrl: directed scenarios followed by random traffic.
module tb_debounce_scan_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] in = '1;
    logic [W-1:0] delay = 8'd5;
    logic         evt_ready = 1'b1;
    logic [N-1:0] out;
    logic         evt_valid;
    logic [1:0]   evt_ch;
    logic         evt_level;
    logic         evt_overrun;

    debounce_scan_ctrl #(.N_CH(N), .CNT_W(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in          (in),
        .delay       (delay),
        .out         (out),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .evt_level   (evt_level),
        .evt_overrun (evt_overrun)
    );

    always #20 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int n_evt = 0;
    int n_ovr = 0;

    typedef struct {
        int ch;
        int level;
    } ev_t;
    ev_t exp_q[$];

    // Reference: input passes two stages, the visited channel accumulates a run of
    // differing visits and commits once the run reaches the effective delay.
    bit [N-1:0] m_s1 = '0;
    bit [N-1:0] m_s2 = '0;
    bit [N-1:0] m_out = '0;
    int         m_run [N];
    int         m_ptr = 0;
    bit         m_valid = 1'b0;
    bit         m_ovr = 1'b0;
    int         mc;
    int         meff;
    bit         mcommit;

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_rng(string name, int got, int lo, int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d..%0d at %0t", name, got, lo, hi, $time);
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_s1    = '0;
            m_s2    = '0;
            m_out   = '0;
            m_ptr   = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            exp_q.delete();
        end else begin
            mc      = m_ptr;
            meff    = (delay == 0) ? 1 : int'(delay);
            mcommit = 1'b0;
            if (m_s2[mc] != m_out[mc]) begin
                m_run[mc]++;
                if (m_run[mc] >= meff) begin
                    mcommit   = 1'b1;
                    m_run[mc] = 0;
                end
            end else begin
                m_run[mc] = 0;
            end
            m_ovr = 1'b0;
            if (mcommit) begin
                m_out[mc] = m_s2[mc];
                if (!m_valid || evt_ready) begin
                    m_valid = 1'b1;
                    exp_q.push_back('{mc, int'(m_out[mc])});
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
            end
            m_s2  = m_s1;
            m_s1  = in;
            m_ptr = (m_ptr + 1) % N;
        end
    end

    always @(negedge clock) begin
        ev_t e;
        chk("out", int'(out), int'(m_out));
        chk("evt_valid", int'(evt_valid), int'(m_valid));
        chk("evt_overrun", int'(evt_overrun), int'(m_ovr));
        if (evt_overrun) n_ovr++;
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL evt_unexpected ch=%0d level=%0d expected=none at %0t",
                         evt_ch, evt_level, $time);
            end else begin
                e = exp_q.pop_front();
                chk("evt_ch", int'(evt_ch), e.ch);
                chk("evt_level", int'(evt_level), e.level);
            end
            n_evt++;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_out(int c, bit lvl, int maxe, output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (out[c] !== lvl && n < maxe);
    endtask

    initial begin
        int n;
        int e0;
        int o0;
        int widths [3] = '{1, 2, 5};

        in = '1;
        tick(3);
        chk("reset_out", int'(out), 0);
        chk("reset_evt_valid", int'(evt_valid), 0);
        in = '0;
        reset_n = 1'b1;
        tick(100);
        chk("post_reset_out", int'(out), 0);
        chk("post_reset_events", n_evt, 0);

        foreach (widths[k]) begin
            in[0] = 1'b1;
            tick(widths[k]);
            in[0] = 1'b0;
            tick(30);
        end
        chk("glitch_out0", int'(out[0]), 0);
        chk("glitch_events", n_evt, 0);

        e0 = n_evt;
        in[2] = 1'b1;
        wait_out(2, 1'b1, 60, n);
        chk_rng("press_latency", n, 19, 22);
        tick(40 - n);
        in[2] = 1'b0;
        wait_out(2, 1'b0, 60, n);
        chk_rng("release_latency", n, 19, 22);
        tick(2);
        chk("press_release_events", n_evt - e0, 2);

        evt_ready = 1'b0;
        o0 = n_ovr;
        in[1] = 1'b1;
        tick(8);
        in[3] = 1'b1;
        tick(40);
        chk("overrun_out", int'(out), 4'b1010);
        chk("held_valid", int'(evt_valid), 1);
        chk("held_ch", int'(evt_ch), 1);
        chk("held_level", int'(evt_level), 1);
        chk("overrun_pulses", n_ovr - o0, 1);
        evt_ready = 1'b1;
        tick(1);
        chk("ready_clears_valid", int'(evt_valid), 0);
        in[1] = 1'b0;
        in[3] = 1'b0;
        tick(40);

        delay = 8'd0;
        in[0] = 1'b1;
        wait_out(0, 1'b1, 60, n);
        chk_rng("delay0_latency", n, 3, 6);
        in[0] = 1'b0;
        tick(10);

        delay = 8'd200;
        in[1] = 1'b1;
        tick(22);
        chk("delay200_not_committed", int'(out[1]), 0);
        delay = 8'd2;
        wait_out(1, 1'b1, 60, n);
        chk_rng("delay_drop_latency", n, 1, 4);
        delay = 8'd5;
        in[1] = 1'b0;
        tick(30);

        in[0] = 1'b1;
        tick(12);
        reset_n = 1'b0;
        tick(2);
        chk("midcount_reset_out", int'(out), 0);
        reset_n = 1'b1;
        wait_out(0, 1'b1, 60, n);
        chk_rng("after_reset_latency", n, 19, 22);
        in[0] = 1'b0;
        tick(30);

        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 39) == 0) in[c] = ~in[c];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            if (i % 200 == 0) delay = W'($urandom_range(0, 6));
            tick(1);
        end
        evt_ready = 1'b1;
        tick(60);
        chk("final_out_settled", int'(out), int'(in));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
